adder_step_sequencer: RTL and testbench
=======================================

Name: adder_step_sequencer

Overview:
- Initiator-side controller for the neuron potential adder: it drives that block's parameter-load and time-step protocol.
- Holds a 6-entry shadow parameter bank (A, B, C, D, VT, U). On command, it replays the bank to the adder as a paced load sequence.
- Issues single-cycle time_step pulses per accepted step request, waits for done and returns final potential and spike over a valid/ready result channel.
- Sits between the core/NoC-side neuron scheduler and one potential_adder instance.

Parameters:
- DATA_W, 32, width of weights, potentials and parameters
- TIMEOUT, 2048, max cycles to wait for done after a time_step pulse (>=2)
- CNT_W, 16, spike counter width (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  write shadow parameter
- cfg_addr  in  3  parameter index 1..6 = A,B,C,D,VT,U; 0 and 7 ignored
- cfg_data  in  DATA_W  parameter value
- cfg_commit  in  1  start load replay
- cfg_busy  out  1  load replay in progress
- step_valid  in  1  step request valid
- step_ready  out  1  step request accepted when high with step_valid
- step_weight  in  DATA_W  input weight for step
- step_decayed  in  DATA_W  decayed potential for step
- step_model  in  2  00 LIF, 01 Izhikevich, 10 QLIF, 11 illegal
- load  out  1  adder load strobe
- init_mode  out  3  adder parameter select
- input_weight  out  DATA_W  adder weight / parameter data
- decayed_potential  out  DATA_W  adder decayed potential
- model  out  2  adder model select
- time_step  out  1  adder step strobe
- final_potential  in  DATA_W  adder result
- done  in  1  adder completion
- spike  in  1  adder spike flag
- res_valid  out  1  result valid
- res_ready  in  1  result consumed
- res_potential  out  DATA_W  captured final potential
- res_spike  out  1  captured spike
- res_status  out  2  00 ok, 01 timeout, 10 illegal model

Behaviour:
- Reset (synchronous, rst high at clk edge): state IDLE. All outputs 0; shadow bank cleared to 0. Applies from any state, including mid-load or mid-wait.
- States: IDLE, LD_ON, LD_OFF, STEP, WAIT, RESP.
- cfg_we writes bank[cfg_addr] in IDLE and RESP only. Writes are ignored while cfg_busy or in STEP/WAIT.
- IDLE:
  - step_ready = !cfg_commit.
  - cfg_commit -> LD_ON with k=1; commit has priority over step_valid in the same cycle.
  - step_valid & step_ready -> latch weight/decayed/model onto the adder outputs. Model 11 -> RESP with status 10, potential 0, spike 0, no time_step. Otherwise -> STEP.
- LD_ON: load=1, init_mode=k, input_weight=bank[k] -> LD_OFF.
- LD_OFF: load=0, init_mode=0.
  - If k=6 -> IDLE; else k+1 -> LD_ON.
  - Full replay = 12 cycles; cfg_busy high throughout, low in the IDLE cycle following.
- STEP: time_step=1 for exactly one cycle; input_weight/decayed_potential/model stable from STEP through WAIT. Wait counter cleared -> WAIT.
- WAIT: time_step=0.
  - done=1 -> capture final_potential and spike, status 00, -> RESP.
  - Otherwise counter+1. If counter reaches TIMEOUT-1 without done -> RESP with status 01, potential 0, spike 0.
  - done and timeout in the same cycle: done wins.
- RESP: res_valid=1, res_* held stable until res_valid & res_ready, then -> IDLE (step_ready high from that IDLE cycle). step_ready=0 in all non-IDLE states.
- Throughput: one step every 4 cycles minimum (accept, STEP, WAIT with immediate done, RESP with res_ready high).
- Outputs are registered; done arriving during LD_ON/LD_OFF/IDLE is ignored.

Optional Feature:
- Macro SEQ_SPIKE_COUNT_EN.
- Defined: adds output spike_count (CNT_W) and input spike_count_clr (1).
  - Counter increments on each RESP entry with status 00 and spike=1.
  - Saturates at all-ones.
  - spike_count_clr zeroes it; clear wins over increment in the same cycle.
  - Reset zeroes it.
- Undefined: ports and counter absent; all other behaviour identical.

Test Plan:
- Write bank A..U = 10,20,30,40,50,5, pulse cfg_commit -> load high on 6 alternating cycles with init_mode 1..6 and input_weight 10,20,30,40,50,5; cfg_busy high 12 cycles; init_mode 0 after.
- IDLE, step LIF weight 25 decayed 25; adder model returns done 3 cycles after time_step with potential 50 spike 1 -> single-cycle time_step, res_valid with res_potential 50, res_spike 1, status 00.
- Step Izhikevich weight 25 decayed 35, done never asserted, TIMEOUT=16 -> res_valid with status 01, potential 0, 16 cycles after time_step.
- step_model 11 -> no time_step, res_valid next cycle with status 10; cfg_commit and step_valid in the same cycle -> load replay starts, step_ready 0.
- Hold res_ready low 5 cycles after a QLIF step (weight 30, decayed 10, done returns potential 40) -> res_potential 40 stable, step_ready 0 until handshake.
- Assert rst during WAIT and at load k=3 -> next cycle all outputs 0, IDLE, bank zeroed. With SEQ_SPIKE_COUNT_EN, three spiking steps -> spike_count 3, then clr -> 0.

Source files
------------

// File: rtl/adder_step_sequencer.sv
// Initiator-side controller for the neuron potential adder: replays a shadow parameter bank
// and sequences time_step / done handshakes. Optional spike counter: SEQ_SPIKE_COUNT_EN.
module adder_step_sequencer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 2048,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SEQ_SPIKE_COUNT_EN
  input  logic              spike_count_clr,
  output logic [CNT_W-1:0]  spike_count,
`endif
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_commit,
  output logic              cfg_busy,
  input  logic              step_valid,
  output logic              step_ready,
  input  logic [DATA_W-1:0] step_weight,
  input  logic [DATA_W-1:0] step_decayed,
  input  logic [1:0]        step_model,
  output logic              load,
  output logic [2:0]        init_mode,
  output logic [DATA_W-1:0] input_weight,
  output logic [DATA_W-1:0] decayed_potential,
  output logic [1:0]        model,
  output logic              time_step,
  input  logic [DATA_W-1:0] final_potential,
  input  logic              done,
  input  logic              spike,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_potential,
  output logic              res_spike,
  output logic [1:0]        res_status
);

  localparam int unsigned WaitW = $clog2(TIMEOUT);

  if (TIMEOUT < 2 || CNT_W < 1) begin : g_param_check
    $error("adder_step_sequencer: TIMEOUT must be >= 2 and CNT_W >= 1");
  end

  typedef enum logic [2:0] {StIdle, StLdOn, StLdOff, StStep, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [WaitW-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] bank_q [6];
  logic [DATA_W-1:0] bank_d [6];
  logic              load_q, load_d, busy_q, busy_d, time_step_q, time_step_d;
  logic [2:0]        init_mode_q, init_mode_d;
  logic [DATA_W-1:0] weight_q, weight_d, decayed_q, decayed_d;
  logic [1:0]        model_q, model_d;
  logic              res_valid_q, res_valid_d, res_spike_q, res_spike_d;
  logic [DATA_W-1:0] res_pot_q, res_pot_d;
  logic [1:0]        res_status_q, res_status_d;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    bank_d       = bank_q;
    load_d       = 1'b0;
    busy_d       = 1'b0;
    time_step_d  = 1'b0;
    init_mode_d  = 3'd0;
    weight_d     = weight_q;
    decayed_d    = decayed_q;
    model_d      = model_q;
    res_valid_d  = 1'b0;
    res_pot_d    = res_pot_q;
    res_spike_d  = res_spike_q;
    res_status_d = res_status_q;

    if (cfg_we && (state_q == StIdle || state_q == StResp) && cfg_addr inside {[3'd1:3'd6]}) begin
      bank_d[cfg_addr - 3'd1] = cfg_data;
    end

    unique case (state_q)
      StIdle: begin
        if (cfg_commit) begin
          state_d     = StLdOn;
          k_d         = 3'd1;
          load_d      = 1'b1;
          busy_d      = 1'b1;
          init_mode_d = 3'd1;
          weight_d    = bank_q[0];
        end else if (step_valid) begin
          weight_d  = step_weight;
          decayed_d = step_decayed;
          model_d   = step_model;
          if (step_model == 2'b11) begin
            state_d      = StResp;
            res_valid_d  = 1'b1;
            res_pot_d    = '0;
            res_spike_d  = 1'b0;
            res_status_d = 2'b10;
          end else begin
            state_d     = StStep;
            time_step_d = 1'b1;
          end
        end
      end
      StLdOn: begin
        state_d = StLdOff;
        busy_d  = 1'b1;
      end
      StLdOff: begin
        if (k_q == 3'd6) begin
          state_d = StIdle;
        end else begin
          state_d     = StLdOn;
          k_d         = k_q + 3'd1;
          load_d      = 1'b1;
          busy_d      = 1'b1;
          init_mode_d = k_q + 3'd1;
          weight_d    = bank_q[k_q];  // bank is zero-based, so this is entry k+1
        end
      end
      StStep: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (done) begin
          state_d      = StResp;
          res_valid_d  = 1'b1;
          res_pot_d    = final_potential;
          res_spike_d  = spike;
          res_status_d = 2'b00;
        end else if (cnt_q == WaitW'(TIMEOUT - 2)) begin
          state_d      = StResp;
          res_valid_d  = 1'b1;
          res_pot_d    = '0;
          res_spike_d  = 1'b0;
          res_status_d = 2'b01;
        end else begin
          cnt_d = cnt_q + WaitW'(1);
        end
      end
      StResp: begin
        if (res_ready) state_d = StIdle;
        else           res_valid_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      k_q          <= 3'd0;
      cnt_q        <= '0;
      for (int i = 0; i < 6; i++) bank_q[i] <= '0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
      time_step_q  <= 1'b0;
      init_mode_q  <= 3'd0;
      weight_q     <= '0;
      decayed_q    <= '0;
      model_q      <= 2'b00;
      res_valid_q  <= 1'b0;
      res_pot_q    <= '0;
      res_spike_q  <= 1'b0;
      res_status_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      bank_q       <= bank_d;
      load_q       <= load_d;
      busy_q       <= busy_d;
      time_step_q  <= time_step_d;
      init_mode_q  <= init_mode_d;
      weight_q     <= weight_d;
      decayed_q    <= decayed_d;
      model_q      <= model_d;
      res_valid_q  <= res_valid_d;
      res_pot_q    <= res_pot_d;
      res_spike_q  <= res_spike_d;
      res_status_q <= res_status_d;
    end
  end

  // Commit takes priority, so a same-cycle step request must not see ready.
  assign step_ready        = (state_q == StIdle) && !cfg_commit && !rst;
  assign cfg_busy          = busy_q;
  assign load              = load_q;
  assign init_mode         = init_mode_q;
  assign input_weight      = weight_q;
  assign decayed_potential = decayed_q;
  assign model             = model_q;
  assign time_step         = time_step_q;
  assign res_valid         = res_valid_q;
  assign res_potential     = res_pot_q;
  assign res_spike         = res_spike_q;
  assign res_status        = res_status_q;

`ifdef SEQ_SPIKE_COUNT_EN
  logic             spike_inc;
  logic [CNT_W-1:0] spike_cnt_q, spike_cnt_d;

  assign spike_inc = (state_q == StWait) && done && spike;

  always_comb begin
    spike_cnt_d = spike_cnt_q;
    if (spike_count_clr) begin
      spike_cnt_d = '0;
    end else if (spike_inc && (spike_cnt_q != '1)) begin
      spike_cnt_d = spike_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) spike_cnt_q <= '0;
    else     spike_cnt_q <= spike_cnt_d;
  end

  assign spike_count = spike_cnt_q;
`endif

endmodule

// File: tb/tb_adder_step_sequencer.sv
// Scoreboard bench for adder_step_sequencer with a behavioural potential-adder responder.
module tb_adder_step_sequencer;
  localparam int unsigned DataW   = 32;
  localparam int unsigned Timeout = 16;
  localparam int unsigned CntW    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_we = 1'b0, cfg_commit = 1'b0, cfg_busy;
  logic [2:0]       cfg_addr = 3'd0;
  logic [DataW-1:0] cfg_data = '0;
  logic             step_valid = 1'b0, step_ready;
  logic [DataW-1:0] step_weight = '0, step_decayed = '0;
  logic [1:0]       step_model = 2'b00;
  logic             load, time_step;
  logic [2:0]       init_mode;
  logic [DataW-1:0] input_weight, decayed_potential;
  logic [1:0]       model;
  logic [DataW-1:0] final_potential = '0;
  logic             done = 1'b0, spike = 1'b0;
  logic             res_valid, res_ready = 1'b0, res_spike;
  logic [DataW-1:0] res_potential;
  logic [1:0]       res_status;
`ifdef SEQ_SPIKE_COUNT_EN
  logic             spike_count_clr = 1'b0;
  logic [CntW-1:0]  spike_count;
`endif

  adder_step_sequencer #(.DATA_W(DataW), .TIMEOUT(Timeout), .CNT_W(CntW)) u_dut (
    .clk              (clk),
    .rst              (rst),
`ifdef SEQ_SPIKE_COUNT_EN
    .spike_count_clr  (spike_count_clr),
    .spike_count      (spike_count),
`endif
    .cfg_we           (cfg_we),
    .cfg_addr         (cfg_addr),
    .cfg_data         (cfg_data),
    .cfg_commit       (cfg_commit),
    .cfg_busy         (cfg_busy),
    .step_valid       (step_valid),
    .step_ready       (step_ready),
    .step_weight      (step_weight),
    .step_decayed     (step_decayed),
    .step_model       (step_model),
    .load             (load),
    .init_mode        (init_mode),
    .input_weight     (input_weight),
    .decayed_potential(decayed_potential),
    .model            (model),
    .time_step        (time_step),
    .final_potential  (final_potential),
    .done             (done),
    .spike            (spike),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_potential    (res_potential),
    .res_spike        (res_spike),
    .res_status       (res_status)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DataW-1:0] pot;
    logic             spk;
    logic [1:0]       status;
  } exp_t;

  exp_t             sb_q[$];
  int               n_checks = 0;
  int               n_fails  = 0;
  int               ts_cnt   = 0;
  bit               adder_en = 1'b0;
  logic [DataW-1:0] mdl_pot  = '0;
  logic             mdl_spk  = 1'b0;
  int               cd       = 0;
  logic [DataW-1:0] exp_bank [6];

  // Adder responder: done three cycles after the time_step cycle, when enabled.
  always @(negedge clk) begin
    done = 1'b0;
    if (rst) begin
      cd = 0;
    end else if (time_step && adder_en) begin
      cd = 3;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        done            = 1'b1;
        final_potential = mdl_pot;
        spike           = mdl_spk;
      end
    end
  end

  always @(posedge clk) if (time_step) ts_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_load"}, load, 0);
    check({tag, "_mode"}, init_mode, 0);
    check({tag, "_busy"}, cfg_busy, 0);
    check({tag, "_ts"}, time_step, 0);
    check({tag, "_iw"}, input_weight, 0);
    check({tag, "_dp"}, decayed_potential, 0);
    check({tag, "_model"}, model, 0);
    check({tag, "_rv"}, res_valid, 0);
    check({tag, "_rp"}, res_potential, 0);
    check({tag, "_rs"}, res_spike, 0);
    check({tag, "_rst"}, res_status, 0);
    check({tag, "_ready"}, step_ready, 0);
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [DataW-1:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  // Called at the negedge of the first LD_ON cycle.
  task automatic replay_check();
    for (int i = 0; i < 12; i++) begin
      check("ld_load", load, (i % 2 == 0));
      check("ld_mode", init_mode, (i % 2 == 0) ? (i / 2 + 1) : 0);
      if (i % 2 == 0) check("ld_data", input_weight, exp_bank[i / 2]);
      check("ld_busy", cfg_busy, 1);
      check("ld_ready", step_ready, 0);
      tick();
    end
    check("ld_end_busy", cfg_busy, 0);
    check("ld_end_load", load, 0);
    check("ld_end_mode", init_mode, 0);
  endtask

  task automatic commit_replay();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    replay_check();
  endtask

  // Returns at the negedge of the STEP (or illegal-model RESP) cycle.
  task automatic do_step(input logic [DataW-1:0] w, input logic [DataW-1:0] d,
                         input logic [1:0] m, input logic [DataW-1:0] pot,
                         input logic spk, input logic [1:0] status);
    int n = 0;
    while (!step_ready && n < 40) begin tick(); n++; end
    check("step_ready_wait", step_ready, 1);
    step_valid = 1'b1; step_weight = w; step_decayed = d; step_model = m;
    sb_q.push_back('{pot: pot, spk: spk, status: status});
    tick();
    step_valid = 1'b0;
  endtask

  task automatic wait_resp(input int exp_lat, input int hold);
    int   n = 0;
    exp_t e = '0;
    while (!res_valid && n < 40) begin tick(); n++; end
    check("resp_lat", n, exp_lat);
    check("sb_nonempty", sb_q.size() != 0, 1);
    if (sb_q.size() != 0) e = sb_q.pop_front();
    check("res_pot", res_potential, e.pot);
    check("res_spike", res_spike, e.spk);
    check("res_status", res_status, e.status);
    check("resp_ready", step_ready, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", res_valid, 1);
      check("hold_pot", res_potential, e.pot);
      check("hold_ready", step_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("resp_cleared", res_valid, 0);
    check("idle_ready", step_ready, 1);
  endtask

  initial begin
    int ts0;
    tick(); tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    #1 check("reset_idle_ready", step_ready, 1);

    // Bank write and replay
    exp_bank = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd5};
    tick();
    for (int i = 0; i < 6; i++) cfg_write(3'(i + 1), exp_bank[i]);
    commit_replay();

    // LIF, done after three cycles
    adder_en = 1'b1; mdl_pot = 32'd50; mdl_spk = 1'b1;
    ts0 = ts_cnt;
    do_step(32'd25, 32'd25, 2'b00, 32'd50, 1'b1, 2'b00);
    check("lif_ts", time_step, 1);
    check("lif_iw", input_weight, 25);
    check("lif_dp", decayed_potential, 25);
    tick();
    check("lif_ts_off", time_step, 0);
    check("lif_iw_wait", input_weight, 25);
    wait_resp(3, 0);
    check("lif_ts_count", ts_cnt - ts0, 1);
`ifdef SEQ_SPIKE_COUNT_EN
    check("cnt_after_lif", spike_count, 1);
`endif

    // Izhikevich, no done -> timeout
    adder_en = 1'b0;
    ts0 = ts_cnt;
    do_step(32'd25, 32'd35, 2'b01, 32'd0, 1'b0, 2'b01);
    check("izh_ts", time_step, 1);
    check("izh_model", model, 1);
    wait_resp(Timeout, 0);
    check("izh_ts_count", ts_cnt - ts0, 1);

    // Illegal model
    ts0 = ts_cnt;
    do_step(32'd1, 32'd2, 2'b11, 32'd0, 1'b0, 2'b10);
    check("ill_ts", time_step, 0);
    wait_resp(0, 0);
    check("ill_ts_count", ts_cnt - ts0, 0);

    // Commit and step request together: commit wins
    cfg_commit = 1'b1; step_valid = 1'b1; step_model = 2'b00;
    #1 check("cc_ready", step_ready, 0);
    tick();
    cfg_commit = 1'b0; step_valid = 1'b0;
    check("cc_ts", time_step, 0);
    replay_check();

    // QLIF with delayed consumer
    adder_en = 1'b1; mdl_pot = 32'd40; mdl_spk = 1'b0;
    do_step(32'd30, 32'd10, 2'b10, 32'd40, 1'b0, 2'b00);
    check("qlif_model", model, 2);
    wait_resp(4, 5);
`ifdef SEQ_SPIKE_COUNT_EN
    check("cnt_after_qlif", spike_count, 1);
`endif

    // Reset while waiting for done
    adder_en = 1'b0;
    do_step(32'd7, 32'd9, 2'b01, 32'd0, 1'b0, 2'b01);
    tick(); tick(); tick();
    check("wait_pre_rst_dp", decayed_potential, 9);
    rst = 1'b1;
    tick();
    check_outputs_zero("rst_wait");
    rst = 1'b0;
    sb_q.delete();
`ifdef SEQ_SPIKE_COUNT_EN
    check("cnt_after_rst", spike_count, 0);
`endif
    tick();
    check("rst_wait_no_resp", res_valid, 0);

    // Reset during replay at k=3, then the bank must read back as zero
    for (int i = 0; i < 6; i++) cfg_write(3'(i + 1), exp_bank[i]);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick(); tick(); tick(); tick();
    check("k3_mode", init_mode, 3);
    check("k3_data", input_weight, 30);
    rst = 1'b1;
    tick();
    check_outputs_zero("rst_load");
    rst = 1'b0;
    tick();
    exp_bank = '{default: '0};
    commit_replay();

`ifdef SEQ_SPIKE_COUNT_EN
    adder_en = 1'b1; mdl_pot = 32'd99; mdl_spk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_step(32'(i), 32'd1, 2'b00, 32'd99, 1'b1, 2'b00);
      wait_resp(4, 0);
    end
    check("cnt_three", spike_count, 3);
    spike_count_clr = 1'b1;
    tick();
    spike_count_clr = 1'b0;
    check("cnt_cleared", spike_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
